controle_pedidos_elevador: RTL and testbench

//  Request scheduler directly upstream of the UP/DOWN floor counter. Latches the

---
 rtl/controle_pedidos_elevador.sv | 187 ++++++++++++++++++
 tb/tb_controle_pedidos_elevador.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controle_pedidos_elevador.sv
`default_nettype none
// ============================================================================
// Module      : controle_pedidos_elevador
// Description : Request scheduler for the UP/DOWN floor counter. Latches the
//               call buttons, compares them with the current floor fed back
//               from the counter, and issues single-cycle MAIS/MENOS step
//               pulses in collective (SCAN) order. Also times the door-open
//               interval at each served floor.
//
//   CLK           in   1  system clock, rising edge
//   reset         in   1  asynchronous, active-low reset
//   EMERG         in   1  emergency stop, level (only with ELEV_EMERGENCIA_EN)
//   CHAMADA       in   N  call buttons, level, bit i = floor i
//   ANDAR         in   3  current floor {B2,B1,B0} from the counter
//   MAIS          out  1  one-cycle step-up pulse
//   MENOS         out  1  one-cycle step-down pulse
//   PORTA_ABERTA  out  1  door open
//   DIRECAO       out  1  1 = up preference, 0 = down preference
//   PENDENTES     out  N  latched pending requests
//
// Build option : define ELEV_EMERGENCIA_EN to add the EMERG input. While
//               EMERG is high the scheduler parks in PARADO with the door
//               open, drops all pending calls and ignores new ones.
//
// Revision    : 1.0 - initial release
// ============================================================================
module controle_pedidos_elevador #(
    parameter int N_ANDARES = 8,
    parameter int T_PASSO   = 4,
    parameter int T_PORTA   = 16
) (
    input  logic                          CLK,
    input  logic                          reset,
`ifdef ELEV_EMERGENCIA_EN
    input  logic                          EMERG,
`endif
    input  logic [N_ANDARES-1:0]          CHAMADA,
    input  logic [$clog2(N_ANDARES)-1:0]  ANDAR,
    output logic                          MAIS,
    output logic                          MENOS,
    output logic                          PORTA_ABERTA,
    output logic                          DIRECAO,
    output logic [N_ANDARES-1:0]          PENDENTES
);

    localparam int C_AW   = $clog2(N_ANDARES);
    localparam int C_TMAX = (T_PASSO > T_PORTA) ? T_PASSO : T_PORTA;
    localparam int C_TW   = $clog2(C_TMAX + 1);

    localparam logic [C_AW-1:0] C_TOPO      = C_AW'(N_ANDARES - 1);
    localparam logic [C_TW-1:0] C_FIM_PASSO = C_TW'(T_PASSO - 1);
    localparam logic [C_TW-1:0] C_FIM_PORTA = C_TW'(T_PORTA - 1);

    localparam logic [2:0] S_PARADO   = 3'd0;
    localparam logic [2:0] S_SUBINDO  = 3'd1;
    localparam logic [2:0] S_DESCENDO = 3'd2;
    localparam logic [2:0] S_ESPERA   = 3'd3;
    localparam logic [2:0] S_PORTA    = 3'd4;

    logic [2:0]           r_state, w_next;
    logic [C_TW-1:0]      r_timer, w_timer_nxt;
    logic                 r_dir, w_dir_nxt;
    logic                 r_mais, w_mais_nxt;
    logic                 r_menos, w_menos_nxt;
    logic                 r_porta, w_porta_nxt;
    logic [N_ANDARES-1:0] r_pend, w_pend_nxt;

    logic [N_ANDARES-1:0] w_mask_acima, w_mask_abaixo;
    logic                 w_acima, w_abaixo, w_aqui;
    logic                 w_emerg;

`ifdef ELEV_EMERGENCIA_EN
    assign w_emerg = EMERG;
`else
    assign w_emerg = 1'b0;
`endif

    // Floors strictly above / below the current one
    always_comb begin
        w_mask_acima  = '0;
        w_mask_abaixo = '0;
        for (int i = 0; i < N_ANDARES; i++) begin
            w_mask_acima[i]  = (i > int'(ANDAR));
            w_mask_abaixo[i] = (i < int'(ANDAR));
        end
    end

    assign w_acima  = |(r_pend & w_mask_acima);
    assign w_abaixo = |(r_pend & w_mask_abaixo);
    assign w_aqui   = r_pend[ANDAR];

    // State and output registers
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_state <= S_PARADO;
            r_timer <= '0;
            r_dir   <= 1'b1;
            r_mais  <= 1'b0;
            r_menos <= 1'b0;
            r_porta <= 1'b0;
            r_pend  <= '0;
        end else begin
            r_state <= w_next;
            r_timer <= w_timer_nxt;
            r_dir   <= w_dir_nxt;
            r_mais  <= w_mais_nxt;
            r_menos <= w_menos_nxt;
            r_porta <= w_porta_nxt;
            r_pend  <= w_pend_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_next      = r_state;
        w_dir_nxt   = r_dir;
        w_timer_nxt = '0;
        case (r_state)
            S_PARADO: begin
                if (w_aqui) begin
                    w_next = S_PORTA;
                end else if (w_acima && (ANDAR != C_TOPO) && (r_dir || !w_abaixo)) begin
                    w_next    = S_SUBINDO;
                    w_dir_nxt = 1'b1;
                end else if (w_abaixo && (ANDAR != '0)) begin
                    w_next    = S_DESCENDO;
                    w_dir_nxt = 1'b0;
                end
            end
            S_SUBINDO, S_DESCENDO: begin
                w_next = S_ESPERA;
            end
            S_ESPERA: begin
                // The wait lets the counter settle ANDAR before it is trusted again
                if (r_timer == C_FIM_PASSO) begin
                    if (w_aqui)
                        w_next = S_PORTA;
                    else if (r_dir && w_acima && (ANDAR != C_TOPO))
                        w_next = S_SUBINDO;
                    else if (!r_dir && w_abaixo && (ANDAR != '0))
                        w_next = S_DESCENDO;
                    else
                        w_next = S_PARADO;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            S_PORTA: begin
                if (r_timer == C_FIM_PORTA)
                    w_next = S_PARADO;
                else
                    w_timer_nxt = r_timer + 1'b1;
            end
            default: begin
                w_next = S_PARADO;
            end
        endcase

        if (w_emerg) begin
            w_next      = S_PARADO;
            w_timer_nxt = '0;
        end
    end

    // Registered-output logic: values the outputs take after the next edge
    always_comb begin
        w_mais_nxt  = (w_next == S_SUBINDO) && (ANDAR != C_TOPO);
        w_menos_nxt = (w_next == S_DESCENDO) && (ANDAR != '0);
        w_porta_nxt = (w_next == S_PORTA) || w_emerg;

        w_pend_nxt = r_pend | CHAMADA;
        // Clearing on entry and while the door is open both served and
        // suppresses re-latching the floor we are standing at
        if ((w_next == S_PORTA) || (r_state == S_PORTA))
            w_pend_nxt[ANDAR] = 1'b0;
        if (w_emerg)
            w_pend_nxt = '0;
    end

    assign MAIS         = r_mais;
    assign MENOS        = r_menos;
    assign PORTA_ABERTA = r_porta;
    assign DIRECAO      = r_dir;
    assign PENDENTES    = r_pend;

endmodule
`default_nettype wire

// File: tb/tb_controle_pedidos_elevador.sv
`default_nettype none
// ============================================================================
// Module      : tb_controle_pedidos_elevador
// Description : Self-checking bench for controle_pedidos_elevador. A counter
//               model closes the ANDAR loop; expected step/door events are
//               queued as calls are driven and popped as the design emits them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_controle_pedidos_elevador;

    localparam int T_PASSO = 4;
    localparam int T_PORTA = 16;
    localparam int EV_UP   = 0;
    localparam int EV_DN   = 16;
    localparam int EV_DOOR = 32;

    logic       CLK;
    logic       reset;
    logic [7:0] CHAMADA;
    logic [2:0] ANDAR;
    logic       MAIS, MENOS, PORTA_ABERTA, DIRECAO;
    logic [7:0] PENDENTES;
`ifdef ELEV_EMERGENCIA_EN
    logic       EMERG;
`endif

    logic       load_en;
    logic [2:0] load_val;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int sb[$];

    bit in_door    = 0;
    int door_len   = 0;
    bit step_chain = 0;
    int last_step  = 0;

    controle_pedidos_elevador #(
        .N_ANDARES (8),
        .T_PASSO   (T_PASSO),
        .T_PORTA   (T_PORTA)
    ) dut (
        .CLK          (CLK),
        .reset        (reset),
`ifdef ELEV_EMERGENCIA_EN
        .EMERG        (EMERG),
`endif
        .CHAMADA      (CHAMADA),
        .ANDAR        (ANDAR),
        .MAIS         (MAIS),
        .MENOS        (MENOS),
        .PORTA_ABERTA (PORTA_ABERTA),
        .DIRECAO      (DIRECAO),
        .PENDENTES    (PENDENTES)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    // UP/DOWN floor counter fed by the step pulses
    always @(posedge CLK) begin
        if (load_en)
            ANDAR <= load_val;
        else if (MAIS && ANDAR != 3'd7)
            ANDAR <= ANDAR + 3'd1;
        else if (MENOS && ANDAR != 3'd0)
            ANDAR <= ANDAR - 3'd1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic expect_evt(input string tag, input int ev);
        int e;
        if (sb.size() == 0) begin
            chk({tag, "_unexpected"}, ev, 32'hFFFF);
        end else begin
            e = sb.pop_front();
            chk(tag, ev, e);
        end
    endtask

    // Output monitor: sampled on the falling edge
    always @(negedge CLK) begin
        if (!reset) begin
            in_door    = 0;
            step_chain = 0;
        end else begin
            if (MAIS || MENOS) begin
                chk("step_excl", int'(MAIS & MENOS), 0);
                chk("step_door_excl", int'(PORTA_ABERTA), 0);
                if (step_chain)
                    chk("step_gap", cyc - last_step, T_PASSO + 1);
                step_chain = 1;
                last_step  = cyc;
                expect_evt("step_evt", (MAIS ? EV_UP : EV_DN) + int'(ANDAR));
            end
            if (PORTA_ABERTA && !in_door) begin
                in_door    = 1;
                door_len   = 0;
                step_chain = 0;
                expect_evt("door_evt", EV_DOOR + int'(ANDAR));
            end
            if (in_door) begin
                if (PORTA_ABERTA) begin
                    door_len++;
                end else begin
                    chk("door_len", door_len, T_PORTA);
                    in_door = 0;
                end
            end
        end
    end

    task automatic set_floor(input logic [2:0] f);
        load_val = f;
        load_en  = 1'b1;
        @(posedge CLK);
        #1 load_en = 1'b0;
    endtask

    task automatic call(input logic [7:0] c);
        CHAMADA = c;
        @(posedge CLK);
        #1 CHAMADA = 8'h00;
    endtask

    task automatic wait_idle(input int budget);
        int  n;
        bit  ok;
        n  = 0;
        ok = 0;
        while (n < budget && !ok) begin
            @(negedge CLK);
            n++;
            if (sb.size() == 0 && !PORTA_ABERTA && !MAIS && !MENOS && !in_door)
                ok = 1;
        end
        if (!ok)
            chk("idle_timeout_queue", sb.size(), 0);
        repeat (3 * (T_PASSO + 1)) @(negedge CLK);
        sb.delete();
    endtask

    task automatic wait_step(input bit up, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!(up ? MAIS : MENOS) && n < budget);
        if (!(up ? MAIS : MENOS))
            chk("step_timeout", n, 0);
    endtask

    initial begin
        reset    = 1'b0;
        CHAMADA  = 8'h00;
        load_en  = 1'b0;
        load_val = 3'd0;
`ifdef ELEV_EMERGENCIA_EN
        EMERG    = 1'b0;
`endif
        ANDAR    = 3'd0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_mais", int'(MAIS), 0);
        chk("rst_menos", int'(MENOS), 0);
        chk("rst_porta", int'(PORTA_ABERTA), 0);
        chk("rst_dir", int'(DIRECAO), 1);
        chk("rst_pend", int'(PENDENTES), 0);
        reset = 1'b1;
        @(posedge CLK);
        #1;

        // Floor 0 -> 3: three up steps, then door
        set_floor(3'd0);
        sb.push_back(EV_UP + 0);
        sb.push_back(EV_UP + 1);
        sb.push_back(EV_UP + 2);
        sb.push_back(EV_DOOR + 3);
        call(8'h08);
        wait_idle(400);
        chk("t2_pend", int'(PENDENTES), 0);

        // Floor 2, calls at 6 and 0 together: up first, then down
        set_floor(3'd2);
        for (int f = 2; f < 6; f++) sb.push_back(EV_UP + f);
        sb.push_back(EV_DOOR + 6);
        for (int f = 6; f > 0; f--) sb.push_back(EV_DN + f);
        sb.push_back(EV_DOOR + 0);
        call(8'h41);
        wait_idle(800);
        chk("t3_dir", int'(DIRECAO), 0);
        chk("t3_pend", int'(PENDENTES), 0);

        // Top floor held call: door two cycles later, no step
        set_floor(3'd7);
        sb.push_back(EV_DOOR + 7);
        CHAMADA = 8'h80;
        @(posedge CLK);
        #1 chk("t4_lat_early", int'(PORTA_ABERTA), 0);
        @(posedge CLK);
        #1 chk("t4_lat_door", int'(PORTA_ABERTA), 1);
        repeat (4) @(posedge CLK);
        #1 CHAMADA = 8'h00;
        wait_idle(200);
        chk("t4_pend7", int'(PENDENTES[7]), 0);

        // 1 -> 5 with a call at 3 arriving while passing floor 2
        set_floor(3'd1);
        sb.push_back(EV_UP + 1);
        call(8'h20);
        begin
            int n;
            n = 0;
            while (ANDAR != 3'd2 && n < 50) begin
                @(negedge CLK);
                n++;
            end
            chk("t5_reach2", int'(ANDAR), 2);
        end
        @(posedge CLK);
        #1;
        sb.push_back(EV_UP + 2);
        sb.push_back(EV_DOOR + 3);
        sb.push_back(EV_UP + 3);
        sb.push_back(EV_UP + 4);
        sb.push_back(EV_DOOR + 5);
        call(8'h08);
        wait_idle(600);
        chk("t5_pend", int'(PENDENTES), 0);

        // Reset while stepping up towards floor 7
        sb.push_back(EV_UP + 5);
        call(8'h80);
        wait_step(1'b1, 20);
        chk("t1_pend_pre", int'(PENDENTES), 8'h80);
        #1 reset = 1'b0;
        #1;
        chk("t1_mais", int'(MAIS), 0);
        chk("t1_menos", int'(MENOS), 0);
        chk("t1_porta", int'(PORTA_ABERTA), 0);
        chk("t1_dir", int'(DIRECAO), 1);
        chk("t1_pend", int'(PENDENTES), 0);
        @(posedge CLK);
        #1 reset = 1'b1;
        wait_idle(100);
        chk("t1_floor_kept", int'(ANDAR), 5);
        chk("t1_pend_after", int'(PENDENTES), 0);

`ifdef ELEV_EMERGENCIA_EN
        // Emergency mid-travel from 5 towards 0
        sb.push_back(EV_DN + 5);
        call(8'h01);
        wait_step(1'b0, 20);
        @(posedge CLK);
        #1;
        sb.push_back(EV_DOOR + int'(ANDAR));
        EMERG   = 1'b1;
        CHAMADA = 8'h42;
        for (int i = 0; i < T_PORTA; i++) begin
            @(posedge CLK);
            #1;
            chk("t6_mais", int'(MAIS), 0);
            chk("t6_menos", int'(MENOS), 0);
            chk("t6_porta", int'(PORTA_ABERTA), 1);
            chk("t6_pend", int'(PENDENTES), 0);
            if (i == 3) CHAMADA = 8'h00;
        end
        EMERG = 1'b0;
        wait_idle(100);
        chk("t6_pend_after", int'(PENDENTES), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
